// File: rtl/phy_rx_pkg.sv
// Shared lane-state encoding and defaults for the N-lane serial receiver.
package phy_rx_pkg;
   localparam logic [7:0] COMMA_DEF      = 8'hBC;
   localparam int         ACTIVE_CNT_DEF = 4;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      COUNT  = 2'd1,
      ACTIVE = 2'd2
   } lane_state_e;

   typedef struct packed {
      logic       vld;
      logic [7:0] data;
   } lane_byte_t;
endpackage

// File: rtl/phy_rx_nlane_ser_par_lane.sv
// One serial lane: bit shifter, comma aligner and byte emitter.
module ser_par_lane
   import phy_rx_pkg::*;
#(
   parameter logic [7:0] COMMA      = COMMA_DEF,
   parameter int         ACTIVE_CNT = ACTIVE_CNT_DEF
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       ser,
   output logic       active,
   output lane_byte_t rx_byte
);
   localparam int            CW   = $clog2(ACTIVE_CNT + 1);
   localparam logic [CW-1:0] LAST = CW'(ACTIVE_CNT - 1);

   lane_state_e   state;
   logic [7:0]    shreg;
   logic [7:0]    sh_nxt;
   logic [2:0]    bit_cnt;
   logic [CW-1:0] comma_cnt;
   logic          boundary;

   // sh_nxt already includes this cycle's bit, so a boundary sees a whole byte
   assign sh_nxt   = {shreg[6:0], ser};
   assign boundary = (bit_cnt == 3'd7);

   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         state     <= SEARCH;
         shreg     <= '0;
         bit_cnt   <= '0;
         comma_cnt <= '0;
         active    <= 1'b0;
         rx_byte   <= '0;
      end else begin
         shreg       <= sh_nxt;
         bit_cnt     <= bit_cnt + 3'd1;
         rx_byte.vld <= 1'b0;
         case (state)
            SEARCH: if (sh_nxt == COMMA) begin
               state     <= COUNT;
               comma_cnt <= CW'(1);
               bit_cnt   <= '0;
            end
            COUNT: if (boundary) begin
               if (sh_nxt == COMMA) begin
                  comma_cnt <= comma_cnt + CW'(1);
                  if (comma_cnt == LAST) begin
                     state  <= ACTIVE;
                     active <= 1'b1;
                  end
               end else begin
                  state     <= SEARCH;
                  comma_cnt <= '0;
               end
            end
            ACTIVE: if (boundary) begin
               rx_byte.vld  <= 1'b1;
               rx_byte.data <= sh_nxt;
            end
            default: state <= SEARCH;
         endcase
      end
   end
endmodule

// File: rtl/phy_rx_nlane.sv
// N-lane receiver: per-lane aligners feeding a deskew/word combiner.
// Optional PHY_RX_ERRCNT_EN adds a saturating lane_error counter port.
module phy_rx_nlane
   import phy_rx_pkg::*;
#(
   parameter int         NUM_LANES  = 2,
   parameter int         DATA_W     = 32,
   parameter logic [7:0] COMMA      = COMMA_DEF,
   parameter int         ACTIVE_CNT = ACTIVE_CNT_DEF
) (
   input  logic                 clk_32f,
   input  logic                 reset,
   input  logic [NUM_LANES-1:0] par_ser,
   output logic [NUM_LANES-1:0] active_ser_par,
   output logic [DATA_W-1:0]    data_output,
   output logic                 valid_output,
   output logic                 lane_error
`ifdef PHY_RX_ERRCNT_EN
   ,
   output logic [15:0]          err_count
`endif
);
   localparam int BEATS = DATA_W / (8 * NUM_LANES);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   lane_byte_t [NUM_LANES-1:0]      rx_byte;
   logic       [NUM_LANES-1:0]      rx_vld;
   logic       [NUM_LANES-1:0][7:0] hold_data;
   logic       [NUM_LANES-1:0]      hold_full;
   logic       [NUM_LANES-1:0]      is_comma;
   logic       [BW-1:0]             beat_cnt;
   logic       [DATA_W-1:0]         word_acc;
   logic       [DATA_W-1:0]         word_nxt;
   logic                            all_active, beat, beat_idle, beat_data, overrun;

   generate
      for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
         ser_par_lane #(.COMMA(COMMA), .ACTIVE_CNT(ACTIVE_CNT)) u_lane (
            .clk_32f (clk_32f),
            .reset   (reset),
            .ser     (par_ser[g]),
            .active  (active_ser_par[g]),
            .rx_byte (rx_byte[g])
         );
         assign rx_vld[g]   = rx_byte[g].vld;
         assign is_comma[g] = (hold_data[g] == COMMA);
      end
   endgenerate

   assign all_active = &active_ser_par;
   assign beat       = &hold_full;
   assign beat_idle  = beat & (&is_comma);
   assign beat_data  = beat & ~(|is_comma);
   // a beat empties every hold, so only a non-beat cycle can overrun
   assign overrun    = (|(rx_vld & hold_full)) & ~beat;

   // byte index 0 sits at the MSB; lane i of beat j lands at j*NUM_LANES+i
   always_comb begin
      word_nxt = word_acc;
      for (int i = 0; i < NUM_LANES; i++)
         word_nxt[DATA_W-1-8*(int'(beat_cnt)*NUM_LANES+i) -: 8] = hold_data[i];
   end

   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         hold_data    <= '0;
         hold_full    <= '0;
         beat_cnt     <= '0;
         word_acc     <= '0;
         data_output  <= '0;
         valid_output <= 1'b0;
         lane_error   <= 1'b0;
      end else begin
         valid_output <= 1'b0;
         lane_error   <= 1'b0;
         if (!all_active) begin
            hold_data <= '0;
            hold_full <= '0;
            beat_cnt  <= '0;
         end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
               if (rx_vld[i]) begin
                  hold_data[i] <= rx_byte[i].data;
                  hold_full[i] <= 1'b1;
               end else if (beat) begin
                  hold_full[i] <= 1'b0;
               end
            end
            if (overrun) begin
               lane_error <= 1'b1;
               beat_cnt   <= '0;
            end else if (beat_data) begin
               if (beat_cnt == BW'(BEATS - 1)) begin
                  data_output  <= word_nxt;
                  valid_output <= 1'b1;
                  beat_cnt     <= '0;
               end else begin
                  word_acc <= word_nxt;
                  beat_cnt <= beat_cnt + BW'(1);
               end
            end else if (beat_idle) begin
               beat_cnt <= '0;
            end else if (beat) begin
               lane_error <= 1'b1;
               beat_cnt   <= '0;
            end
         end
      end
   end

`ifdef PHY_RX_ERRCNT_EN
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset)
         err_count <= '0;
      else if (lane_error && err_count != 16'hFFFF)
         err_count <= err_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_phy_rx_nlane.sv
// Self-checking bench: 2-lane/32-bit DUT with randomized beat streams and a
// 4-lane/64-bit DUT for wide-word and error-count scenarios.
module tb_phy_rx_nlane;
   localparam logic [7:0] BC = 8'hBC;
   typedef logic [1:0][7:0] slot_t;
   typedef logic [3:0][7:0] slot4_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic [1:0]  par_ser;
   logic [1:0]  active;
   logic [31:0] dout;
   logic        valid, lerr;
   logic [3:0]  par_ser4 = '0;
   logic [3:0]  active4;
   logic [63:0] dout4;
   logic        valid4, lerr4;
`ifdef PHY_RX_ERRCNT_EN
   logic [15:0] err_count2, err_count4;
`endif

   phy_rx_nlane #(.NUM_LANES(2), .DATA_W(32)) dut (
      .clk_32f(clk), .reset(reset), .par_ser(par_ser), .active_ser_par(active),
      .data_output(dout), .valid_output(valid), .lane_error(lerr)
`ifdef PHY_RX_ERRCNT_EN
      , .err_count(err_count2)
`endif
   );

   phy_rx_nlane #(.NUM_LANES(4), .DATA_W(64)) dut4 (
      .clk_32f(clk), .reset(reset), .par_ser(par_ser4), .active_ser_par(active4),
      .data_output(dout4), .valid_output(valid4), .lane_error(lerr4)
`ifdef PHY_RX_ERRCNT_EN
      , .err_count(err_count4)
`endif
   );

   int n_checks = 0, n_fail = 0;

   // slot stream for the 2-lane DUT; idle slots are filled with commas
   slot_t slot_mem [0:1023];
   int    wr_ptr = 0, rd_ptr = 0;
   int    dly0 = 0, dly1 = 0;
   logic  bitq0[$], bitq1[$];

   initial begin
      slot_t s;
      par_ser = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bitq0.delete();
            bitq1.delete();
            repeat (dly0) bitq0.push_back(1'b0);
            repeat (dly1) bitq1.push_back(1'b0);
            par_ser = '0;
         end else begin
            if (bitq0.size() == 0 || bitq1.size() == 0) begin
               if (rd_ptr < wr_ptr) begin
                  s = slot_mem[rd_ptr];
                  rd_ptr++;
               end else s = {BC, BC};
               for (int b = 7; b >= 0; b--) begin
                  bitq0.push_back(s[0][b]);
                  bitq1.push_back(s[1][b]);
               end
            end
            par_ser = {bitq1.pop_front(), bitq0.pop_front()};
         end
      end
   end

   logic [31:0] got_w[$];
   logic [63:0] got_w4[$];
   int          got_err = 0, got_err4 = 0;
   always @(negedge clk) begin
      if (valid)  got_w.push_back(dout);
      if (valid4) got_w4.push_back(dout4);
      if (lerr)   got_err++;
      if (lerr4)  got_err4++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [31:0] exp_w[$];

   function automatic slot_t mk2(input logic [7:0] l0, input logic [7:0] l1);
      return {l1, l0};
   endfunction

   function automatic slot4_t mk4(input logic [7:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic logic [7:0] rnd_data();
      logic [7:0] v;
      v = 8'($urandom);
      while (v == BC) v = 8'($urandom);
      return v;
   endfunction

   task automatic push(input slot_t s);
      slot_mem[wr_ptr] = s;
      wr_ptr++;
   endtask

   // beat-level reference: idle resets the word, mixed errors, data fills bytes
   task automatic model(input int first, input int last, output int e);
      int cnt, nc;
      logic [31:0] acc;
      slot_t s;
      exp_w.delete();
      e = 0; cnt = 0; acc = '0;
      for (int k = first; k < last; k++) begin
         s = slot_mem[k];
         nc = 0;
         for (int i = 0; i < 2; i++) if (s[i] == BC) nc++;
         if (nc == 2) cnt = 0;
         else if (nc == 0) begin
            for (int i = 0; i < 2; i++) acc[31-8*(cnt*2+i) -: 8] = s[i];
            cnt++;
            if (cnt == 2) begin
               exp_w.push_back(acc);
               cnt = 0;
            end
         end else begin
            e++;
            cnt = 0;
         end
      end
   endtask

   task automatic do_reset(input int a, input int b);
      dly0 = a; dly1 = b;
      @(posedge clk); #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      @(posedge clk); #2 reset = 1'b0;
   endtask

   task automatic wait_lock(output bit ok);
      for (int c = 0; c < 400 && active !== 2'b11; c++) @(negedge clk);
      ok = (active === 2'b11);
   endtask

   task automatic send4(input slot4_t s);
      for (int b = 7; b >= 0; b--) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) par_ser4[i] = s[i][b];
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++; if (active !== 2'b00) begin n_fail++; $display("FAIL reset_active: got %b want 00", active); end
      n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", dout); end
      n_checks++; if (valid !== 1'b0 || lerr !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: valid=%b err=%b want 0", valid, lerr); end
      n_checks++; if (active4 !== 4'h0 || dout4 !== 64'h0) begin n_fail++; $display("FAIL reset_dut4: active=%b data=%h want 0", active4, dout4); end
   endtask

   task automatic test_lock();
      int wb;
      wb = got_w.size();
      do_reset(0, 0);
      repeat (28) @(posedge clk); #1;
      n_checks++; if (active !== 2'b00) begin n_fail++; $display("FAIL lock_3commas: got %b want 00", active); end
      repeat (6) @(posedge clk); #1;
      n_checks++; if (active !== 2'b11) begin n_fail++; $display("FAIL lock_4commas: got %b want 11", active); end
      n_checks++; if (got_w.size() != wb) begin n_fail++; $display("FAIL lock_no_valid: got %0d pulses want 0", got_w.size() - wb); end
   endtask

   task automatic test_basic_word();
      int wb, eb;
      wb = got_w.size(); eb = got_err;
      push(mk2(8'hAA, 8'hBB));
      push(mk2(8'hCC, 8'hDD));
      repeat (48) @(negedge clk);
      n_checks++; if (got_w.size() - wb != 1) begin n_fail++; $display("FAIL basic_count: got %0d words want 1", got_w.size() - wb); end
      else begin
         n_checks++; if (got_w[wb] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL basic_word: got %h want AABBCCDD", got_w[wb]); end
      end
      n_checks++; if (dout !== 32'hAABBCCDD) begin n_fail++; $display("FAIL basic_hold: got %h want AABBCCDD", dout); end
      n_checks++; if (got_err != eb) begin n_fail++; $display("FAIL basic_err: got %0d want 0", got_err - eb); end
   endtask

   task automatic test_skew();
      int wb, eb;
      bit ok;
      do_reset(0, 3);
      wait_lock(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL skew3_lock: active=%b want 11", active); end
      wb = got_w.size(); eb = got_err;
      push(mk2(8'hAA, 8'hBB));
      push(mk2(8'hCC, 8'hDD));
      repeat (48) @(negedge clk);
      n_checks++; if (got_w.size() - wb != 1 || got_w[got_w.size()-1] !== 32'hAABBCCDD) begin
         n_fail++; $display("FAIL skew3_word: got %0d words last %h want 1 of AABBCCDD", got_w.size() - wb, dout); end
      n_checks++; if (got_err != eb) begin n_fail++; $display("FAIL skew3_err: got %0d want 0", got_err - eb); end
      do_reset(0, 9);
      wait_lock(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL skew9_lock: active=%b want 11", active); end
      wb = got_w.size(); eb = got_err;
      push(mk2(8'hAA, 8'hBB));
      push(mk2(8'hCC, 8'hDD));
      repeat (48) @(negedge clk);
      n_checks++; if (got_err == eb) begin n_fail++; $display("FAIL skew9_err: got 0 errors want >0"); end
      n_checks++; if (got_w.size() != wb) begin n_fail++; $display("FAIL skew9_valid: got %0d words want 0", got_w.size() - wb); end
   endtask

   task automatic test_mixed_beat();
      int wb, eb, first, exp_e;
      bit ok;
      do_reset(0, 0);
      wait_lock(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL mixed_lock: active=%b want 11", active); end
      wb = got_w.size(); eb = got_err; first = wr_ptr;
      push(mk2(8'hAA, BC));
      push(mk2(8'h11, 8'h22));
      push(mk2(8'h33, 8'h44));
      model(first, wr_ptr, exp_e);
      repeat (56) @(negedge clk);
      n_checks++; if (got_err - eb != exp_e) begin n_fail++; $display("FAIL mixed_err: got %0d want %0d", got_err - eb, exp_e); end
      n_checks++; if (got_w.size() - wb != 1 || got_w[got_w.size()-1] !== 32'h11223344) begin
         n_fail++; $display("FAIL mixed_next_word: got %0d words last %h want 1 of 11223344", got_w.size() - wb, dout); end
   endtask

   task automatic test_fallback_and_reset();
      int wb;
      bit ok;
      dly0 = 0; dly1 = 0;
      @(posedge clk); #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      push(mk2(BC, BC)); push(mk2(BC, BC)); push(mk2(BC, BC)); push(mk2(8'h55, BC));
      @(posedge clk); #2 reset = 1'b0;
      repeat (36) @(posedge clk); #1;
      n_checks++; if (active !== 2'b10) begin n_fail++; $display("FAIL fallback_active: got %b want 10", active); end
      wait_lock(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL fallback_relock: active=%b want 11", active); end
      push(mk2(8'h12, 8'h34));
      push(mk2(8'h56, 8'h78));
      repeat (48) @(negedge clk);
      n_checks++; if (dout !== 32'h12345678) begin n_fail++; $display("FAIL pre_reset_word: got %h want 12345678", dout); end
      wb = got_w.size();
      push(mk2(8'h9A, 8'hBD));
      repeat (12) @(negedge clk);
      @(posedge clk); #3 reset = 1'b1;
      #1;
      n_checks++; if (active !== 2'b00 || dout !== 32'h0 || valid !== 1'b0 || lerr !== 1'b0) begin
         n_fail++; $display("FAIL midword_reset: active=%b data=%h valid=%b err=%b want all 0", active, dout, valid, lerr); end
      do_reset(0, 0);
      wait_lock(ok);
      push(mk2(8'hAB, 8'hCD));
      push(mk2(8'hEF, 8'h01));
      repeat (48) @(negedge clk);
      n_checks++; if (got_w.size() - wb != 1 || got_w[got_w.size()-1] !== 32'hABCDEF01) begin
         n_fail++; $display("FAIL post_reset_word: got %0d words last %h want 1 of ABCDEF01", got_w.size() - wb, dout); end
   endtask

   task automatic test_random();
      int wb, eb, first, exp_e, r;
      bit ok;
      for (int it = 0; it < 4; it++) begin
         do_reset(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         wait_lock(ok);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_lock[%0d]: active=%b want 11", it, active); end
         wb = got_w.size(); eb = got_err; first = wr_ptr;
         for (int k = 0; k < 16; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) push(mk2(rnd_data(), rnd_data()));
            else if (r < 8) push(mk2(BC, BC));
            else if (r == 8) push(mk2(BC, rnd_data()));
            else push(mk2(rnd_data(), BC));
         end
         model(first, wr_ptr, exp_e);
         repeat (200) @(negedge clk);
         n_checks++; if (got_err - eb != exp_e) begin n_fail++; $display("FAIL rand_err[%0d]: got %0d want %0d", it, got_err - eb, exp_e); end
         n_checks++; if (got_w.size() - wb != exp_w.size()) begin
            n_fail++; $display("FAIL rand_count[%0d]: got %0d want %0d", it, got_w.size() - wb, exp_w.size()); end
         else begin
            for (int k = 0; k < exp_w.size(); k++) begin
               n_checks++; if (got_w[wb+k] !== exp_w[k]) begin
                  n_fail++; $display("FAIL rand_word[%0d.%0d]: got %h want %h", it, k, got_w[wb+k], exp_w[k]); end
            end
         end
      end
   endtask

   task automatic test_4lane();
      int wb, eb;
      do_reset(0, 0);
      wb = got_w4.size(); eb = got_err4;
      repeat (5) send4(mk4(BC, BC, BC, BC));
      n_checks++; if (active4 !== 4'hF) begin n_fail++; $display("FAIL w4_lock: got %b want 1111", active4); end
      send4(mk4(BC, 8'h11, BC, 8'h22));
      send4(mk4(8'h33, BC, BC, BC));
      send4(mk4(BC, 8'h44, 8'h55, 8'h66));
      send4(mk4(BC, BC, BC, BC));
      send4(mk4(8'h01, 8'h02, 8'h03, 8'h04));
      send4(mk4(8'h05, 8'h06, 8'h07, 8'h08));
      repeat (3) send4(mk4(BC, BC, BC, BC));
      n_checks++; if (got_err4 - eb != 3) begin n_fail++; $display("FAIL w4_err: got %0d want 3", got_err4 - eb); end
      n_checks++; if (got_w4.size() - wb != 1 || dout4 !== 64'h0102030405060708) begin
         n_fail++; $display("FAIL w4_word: got %0d words data %h want 1 of 0102030405060708", got_w4.size() - wb, dout4); end
`ifdef PHY_RX_ERRCNT_EN
      n_checks++; if (err_count4 !== 16'd3) begin n_fail++; $display("FAIL w4_err_count: got %0d want 3", err_count4); end
`endif
      par_ser4 = '0;
   endtask

   initial begin
      test_reset();
      test_lock();
      test_basic_word();
      test_skew();
      test_mixed_beat();
      test_fallback_and_reset();
      test_random();
      test_4lane();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/phy_rx_nlane.md
PHY_RX_NLANE -- requirements
Module: phy_rx_nlane

Interface
REQ-001 Parameter NUM_LANES, default 2: number of serial receive lanes; legal values 1, 2, 4, 8.
REQ-002 Parameter DATA_W, default 32: output word width; DATA_W/8 SHALL be a multiple of NUM_LANES.
REQ-003 Parameter COMMA, default 8'hBC: idle/alignment byte.
REQ-004 Parameter ACTIVE_CNT, default 4: consecutive aligned commas required to activate a lane.
REQ-005 clk_32f  input  1  single bit-rate clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 par_ser  input  NUM_LANES  serial data, one bit per lane per clk_32f cycle, MSB of each byte first.
REQ-008 active_ser_par  output  NUM_LANES  per-lane lock indication.
REQ-009 data_output  output  DATA_W  last assembled word.
REQ-010 valid_output  output  1  one-cycle pulse marking a new data_output.
REQ-011 lane_error  output  1  one-cycle pulse on skew overrun or mixed beat.

Function
REQ-012 Each lane SHALL shift par_ser[i] into an 8-bit register every cycle.
REQ-013 Lane FSM states: SEARCH, COUNT, ACTIVE; reset state SEARCH.
REQ-014 SEARCH: when the 8 most recent bits equal COMMA, SHALL enter COUNT with comma count 1 and bit counter 0 (byte boundary fixed).
REQ-015 COUNT: at each byte boundary, comma increments count, reaching ACTIVE_CNT enters ACTIVE; non-comma returns to SEARCH, count 0.
REQ-016 ACTIVE: SHALL set active_ser_par[i]=1 and emit one byte per 8 cycles into a 1-entry hold register; ACTIVE exits only on reset.
REQ-017 Combiner idle while any lane is not ACTIVE; hold registers cleared, beat counter 0.
REQ-018 A beat fires in the cycle all hold registers are full; all holds clear that cycle.
REQ-019 Beat with all bytes == COMMA: idle; beat counter reset to 0, partial word discarded, no pulse.
REQ-020 Beat with all bytes != COMMA: data; lane i byte at beat j SHALL occupy byte index j*NUM_LANES+i, index 0 at the MSB of data_output.
REQ-021 Mixed beat (some comma, some data): lane_error pulse, partial word discarded, beat counter 0.
REQ-022 After beat DATA_W/(8*NUM_LANES)-1 completes a word, data_output SHALL update and valid_output pulse exactly one cycle after the completing beat; beat counter wraps to 0.
REQ-023 A byte arriving into an already full hold register (skew >= 8 bits) SHALL overwrite it, pulse lane_error and discard the partial word.
REQ-024 data_output SHALL hold its value between pulses.

Reset
REQ-025 On reset: all lanes SEARCH, counters 0, holds empty, active_ser_par=0, data_output=0, valid_output=0, lane_error=0.
REQ-026 Reset mid-word SHALL discard the partial word with no valid_output pulse.

Configuration
REQ-027 Macro PHY_RX_ERRCNT_EN: when defined, adds output err_count (16 bits), incrementing on every lane_error pulse, saturating at 16'hFFFF, cleared by reset; when undefined, the port and counter SHALL not exist and all other behaviour is identical.

Structure
REQ-028 Shared package phy_rx_pkg SHALL hold lane state encoding, default COMMA, and ACTIVE_CNT defaults.
REQ-029 Per-lane deserializer/aligner SHALL be sub-module ser_par_lane, instantiated NUM_LANES times with generate.

Verification (NUM_LANES=2, DATA_W=32 unless stated)
REQ-030 Both lanes send 4x BC -> active_ser_par goes 2'b11 at the 4th comma boundary; valid_output stays 0.
REQ-031 After lock, lane0 AA,CC, lane1 BB,DD -> data_output=32'hAABBCCDD, valid_output single pulse 1 cycle after second beat.
REQ-032 Lane1 delayed 3 bits from lane0, same data -> same 32'hAABBCCDD; delay 9 bits -> lane_error pulse, no valid.
REQ-033 Lane0 AA, lane1 BC in one beat -> lane_error pulse, next clean word assembles correctly.
REQ-034 3x BC then 0x55 on lane0 -> lane0 returns to SEARCH, active_ser_par[0]=0; reset asserted mid-word -> all outputs 0 immediately.
REQ-035 NUM_LANES=4, DATA_W=64, PHY_RX_ERRCNT_EN defined, 3 mixed beats -> err_count=3, word 64'h0102030405060708 assembled over 2 beats.
